seq_multiplier_v2: RTL and testbench

Parametrised radix-2 shift-add sequential multiplier with a signed/unsigned mode select and a start/busy/done handshake. It succeeds the fixed unsigned 24-bit shift-add multiplier in the multiplier library and sits beside the combinational multipliers as the area-minimal option. It computes one N×N→2N product every N+2 clocks. Operands are captured at start and the result is held stable until the next accepted start.

---
 rtl/mul_pkg.sv | 22 ++
 rtl/seq_multiplier_v2_if.sv | 22 ++
 rtl/seq_multiplier_v2.sv | 88 ++++++++
 tb/tb_seq_multiplier_v2.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential and combinational multipliers.
// abs_n works on a fixed wide vector so every operand width up to ABS_W/2-1 can share it.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int ABS_W = 128;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Two's-complement negate when neg is set; callers zero-extend and truncate.
    function automatic logic [ABS_W-1:0] abs_n(input logic [ABS_W-1:0] x, input logic neg);
        return neg ? (~x + ABS_W'(1)) : x;
    endfunction

endpackage

// File: rtl/seq_multiplier_v2_if.sv
// Start/busy/done handshake and operand/result bus of the sequential multiplier.
interface seq_multiplier_v2_if #(
    parameter int N = 24
);
    logic           start;
    logic           is_signed;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_multiplier_v2.sv
// Radix-2 shift-add multiplier on operand magnitudes; the sign is applied once in FIX.
// One N x N -> 2N product every N+2 clocks; product holds until the next FIX or reset.
module seq_multiplier_v2
    import mul_pkg::*;
#(
    parameter int N = 24
) (
    input  logic                clk,
    input  logic                rst,
    seq_multiplier_v2_if.slave  bus
);

    localparam int             CW   = cnt_width(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [N:0]     acc_q;
    logic [N-1:0]   mag_a_q;
    logic [N-1:0]   mag_b_q;
    logic           neg_q;
    logic [2*N-1:0] product_q;
    logic           done_q;

    logic [ABS_W-1:0] abs_a_d;
    logic [ABS_W-1:0] abs_b_d;
    logic [ABS_W-1:0] signed_prod_d;
    logic [N:0]       sum_d;

    always_comb begin
        abs_a_d       = abs_n(ABS_W'(bus.a), bus.is_signed & bus.a[N-1]);
        abs_b_d       = abs_n(ABS_W'(bus.b), bus.is_signed & bus.b[N-1]);
        signed_prod_d = abs_n(ABS_W'({acc_q[N-1:0], mag_b_q}), neg_q);
        sum_d         = acc_q + (mag_b_q[0] ? {1'b0, mag_a_q} : {(N+1){1'b0}});
    end

    // High bits of the shared wide helper are structurally zero/unused here.
    logic unused_hi;
    assign unused_hi = ^{abs_a_d[ABS_W-1:N], abs_b_d[ABS_W-1:N],
                         signed_prod_d[ABS_W-1:2*N], acc_q[N]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mag_a_q <= abs_a_d[N-1:0];
                        mag_b_q <= abs_b_d[N-1:0];
                        neg_q   <= bus.is_signed & (bus.a[N-1] ^ bus.b[N-1]);
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    // The add's carry lands in acc bit N and is shifted down, never lost.
                    acc_q   <= {1'b0, sum_d[N:1]};
                    mag_b_q <= {sum_d[0], mag_b_q[N-1:1]};
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    product_q <= signed_prod_d[2*N-1:0];
                    done_q    <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier_v2.sv
// Scoreboard bench: directed N=8 handshake/reset cases, then random traffic at N=8, 24, 2.
module tb_seq_multiplier_v2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_multiplier_v2_if #(.N(8))  if8  ();
    seq_multiplier_v2_if #(.N(24)) if24 ();
    seq_multiplier_v2_if #(.N(2))  if2  ();

    seq_multiplier_v2 #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    seq_multiplier_v2 #(.N(24)) dut24 (.clk(clk), .rst(rst), .bus(if24));
    seq_multiplier_v2 #(.N(2))  dut2  (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        logic [63:0] p;
        int          c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: sign-extend (if signed) into 64 bits, multiply, keep 2n bits.
    function automatic logic [63:0] ref_mul(input int n, input logic [63:0] a,
                                            input logic [63:0] b, input bit s);
        logic [63:0] mask;
        logic [63:0] ae;
        logic [63:0] be;
        mask = (64'd1 << n) - 64'd1;
        ae = a & mask;
        be = b & mask;
        if (s && ae[n-1]) ae = ae | ~mask;
        if (s && be[n-1]) be = be | ~mask;
        return (ae * be) & ((64'd1 << (2 * n)) - 64'd1);
    endfunction

    function automatic bit get_busy(input int id);
        case (id)
            0: return if8.busy;
            1: return if24.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic int qsize(input int id);
        case (id)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic drive(input int id, input bit st, input logic [63:0] a,
                         input logic [63:0] b, input bit s);
        case (id)
            0: begin if8.start = st;  if8.a = a[7:0];   if8.b = b[7:0];   if8.is_signed = s;  end
            1: begin if24.start = st; if24.a = a[23:0]; if24.b = b[23:0]; if24.is_signed = s; end
            default: begin if2.start = st; if2.a = a[1:0]; if2.b = b[1:0]; if2.is_signed = s; end
        endcase
    endtask

    task automatic issue(input int id, input logic [63:0] a, input logic [63:0] b,
                         input bit s, input logic [63:0] req, output int acc);
        int   g;
        exp_t e;
        g = 0;
        @(negedge clk);
        while (get_busy(id) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            chk("issue_wait_timeout", 64'(g), 64'd0);
            acc = -1;
            return;
        end
        drive(id, 1'b1, a, b, s);
        @(posedge clk);
        #1;
        acc = cyc;
        e.p = req;
        e.c = acc;
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
        drive(id, 1'b0, 64'($urandom), 64'($urandom), 1'($urandom));
    endtask

    task automatic wait_idle(input int id);
        int g;
        g = 0;
        while ((qsize(id) != 0 || get_busy(id)) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) chk("idle_timeout", 64'(qsize(id)), 64'd0);
    endtask

    // One monitor per instance: product/latency at done, hold between FIX edges, clear on reset.
    logic [63:0] prev0 = '0, prev1 = '0, prev2 = '0;
    bit          pd0 = 0, pd1 = 0, pd2 = 0;

    always begin : mon8
        bit   re;
        exp_t e;
        @(posedge clk);
        re = rst;
        #1;
        if (!re) begin
            chk("n8_reset_out", {if8.busy, if8.done, 62'(if8.product)}, 64'd0);
            prev0 = '0;
        end else if (if8.done) begin
            chk("n8_done_width", 64'(pd0), 64'd0);
            if (q0.size() == 0) begin
                chk("n8_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q0.pop_front();
                chk("n8_product", 64'(if8.product), e.p);
                chk("n8_latency", 64'(cyc - e.c), 64'd9);
            end
            prev0 = 64'(if8.product);
        end else begin
            chk("n8_hold", 64'(if8.product), prev0);
        end
        pd0 = if8.done;
    end

    always begin : mon24
        bit   re;
        exp_t e;
        @(posedge clk);
        re = rst;
        #1;
        if (!re) begin
            chk("n24_reset_out", {if24.busy, if24.done, 62'(if24.product)}, 64'd0);
            prev1 = '0;
        end else if (if24.done) begin
            chk("n24_done_width", 64'(pd1), 64'd0);
            if (q1.size() == 0) begin
                chk("n24_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                chk("n24_product", 64'(if24.product), e.p);
                chk("n24_latency", 64'(cyc - e.c), 64'd25);
            end
            prev1 = 64'(if24.product);
        end else begin
            chk("n24_hold", 64'(if24.product), prev1);
        end
        pd1 = if24.done;
    end

    always begin : mon2
        bit   re;
        exp_t e;
        @(posedge clk);
        re = rst;
        #1;
        if (!re) begin
            chk("n2_reset_out", {if2.busy, if2.done, 62'(if2.product)}, 64'd0);
            prev2 = '0;
        end else if (if2.done) begin
            chk("n2_done_width", 64'(pd2), 64'd0);
            if (q2.size() == 0) begin
                chk("n2_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q2.pop_front();
                chk("n2_product", 64'(if2.product), e.p);
                chk("n2_latency", 64'(cyc - e.c), 64'd3);
            end
            prev2 = 64'(if2.product);
        end else begin
            chk("n2_hold", 64'(if2.product), prev2);
        end
        pd2 = if2.done;
    end

    task automatic run_random(input int id, input int n, input int count);
        logic [63:0] a;
        logic [63:0] b;
        bit          s;
        int          acc;
        for (int i = 0; i < count; i++) begin
            a = 64'($urandom);
            b = 64'($urandom);
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: a = 64'd1 << (n - 1);
                1: b = 64'd1 << (n - 1);
                2: a = (64'd1 << n) - 64'd1;
                3: b = 64'd0;
                default: ;
            endcase
            issue(id, a, b, s, ref_mul(n, a, b, s), acc);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        wait_idle(id);
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog_timeout cycles=%0d", cyc);
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin : stim
        int acc1;
        int acc2;
        int nb;
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(1, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(2, 1'b0, 64'd0, 64'd0, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(if8.busy), 64'd0);
        chk("reset_done", 64'(if8.done), 64'd0);
        chk("reset_product", 64'(if8.product), 64'd0);
        rst = 1'b1;

        // Unsigned max operands, with busy duration.
        issue(0, 64'hFF, 64'hFF, 1'b0, 64'hFE01, acc1);
        nb = 0;
        while (if8.busy && nb < 50) begin
            nb++;
            @(posedge clk);
            #1;
        end
        chk("busy_cycles", 64'(nb), 64'd9);
        wait_idle(0);

        // Most-negative operands, issued back to back.
        issue(0, 64'h80, 64'h80, 1'b1, 64'h4000, acc1);
        issue(0, 64'h80, 64'h7F, 1'b1, 64'hC080, acc2);
        chk("b2b_gap", 64'(acc2 - acc1), 64'd10);
        issue(0, 64'hFD, 64'h05, 1'b1, 64'hFFF1, acc1);
        issue(0, 64'hFD, 64'h05, 1'b0, 64'h04F1, acc1);
        wait_idle(0);

        // A start pulse mid-CALC must not disturb the running operation.
        issue(0, 64'h12, 64'h34, 1'b0, 64'h03A8, acc1);
        repeat (3) @(negedge clk);
        drive(0, 1'b1, 64'hFF, 64'hFF, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 64'h00, 64'h00, 1'b0);
        wait_idle(0);
        repeat (12) @(negedge clk);

        // Reset sampled at CALC iteration 4 aborts the operation.
        issue(0, 64'h55, 64'h66, 1'b0, 64'h21DE, acc1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        q0.delete();
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(if8.busy), 64'd0);
        chk("abort_done", 64'(if8.done), 64'd0);
        chk("abort_product", 64'(if8.product), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (14) @(negedge clk);
        issue(0, 64'h07, 64'h09, 1'b0, 64'h003F, acc1);
        wait_idle(0);

        fork
            run_random(0, 8, 1500);
            run_random(1, 24, 1500);
            run_random(2, 2, 1500);
        join
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
